// File: rtl/host_line_bridge_pkg.sv
// host_bridge_pkg: shared constants and types for the cache-line to host-burst
// bridge. mem_arb imports the op encodings from here as well.
//   OP_*            : 2-bit request codes on the processor side
//   LINE_W/HOST_W   : line and beat widths; BEATS beats per line
//   bridge_state_t  : bridge FSM state encoding
package host_bridge_pkg;

    localparam int unsigned LINE_W = 512;
    localparam int unsigned HOST_W = 64;
    localparam int unsigned BEATS  = LINE_W / HOST_W;
    localparam int unsigned CNT_W  = $clog2(BEATS);

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_RSVD = 2'b10;
    localparam logic [1:0] OP_WR   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_BEATS,
        RD_DONE,
        RD_VALID,
        WR_REQ,
        WR_BEATS,
        WR_DONE
    } bridge_state_t;

    // Line-aligned byte address: the low six offset bits are dropped.
    function automatic logic [31:0] line_align(input logic [31:0] a);
        return a & ~32'h0000_003F;
    endfunction

endpackage

// File: rtl/host_line_bridge_if.sv
// host_line_bridge_if: host memory port of the bridge.
//   hreq_*  : burst request (valid/ready, wr flag, line-aligned address)
//   hwr_*   : write beats (valid/ready, data, last on beat 7)
//   hrd_*   : read beats (strobe + data, no backpressure)
// master = bridge side, slave = host memory side.
interface host_line_bridge_if;
    import host_bridge_pkg::*;

    logic              hreq_valid;
    logic              hreq_ready;
    logic              hreq_wr;
    logic [31:0]       hreq_addr;
    logic              hwr_valid;
    logic              hwr_ready;
    logic [HOST_W-1:0] hwr_data;
    logic              hwr_last;
    logic              hrd_valid;
    logic [HOST_W-1:0] hrd_data;

    modport master (
        output hreq_valid, hreq_wr, hreq_addr,
        output hwr_valid, hwr_data, hwr_last,
        input  hreq_ready, hwr_ready, hrd_valid, hrd_data
    );

    modport slave (
        input  hreq_valid, hreq_wr, hreq_addr,
        input  hwr_valid, hwr_data, hwr_last,
        output hreq_ready, hwr_ready, hrd_valid, hrd_data
    );

endinterface

// File: rtl/host_line_bridge_line_pack.sv
// line_pack: beat pack/unpack storage for host_line_bridge.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   cnt_clr_i       : return the beat counter to 0
//   wr_load_i       : capture wr_line_i as the outgoing write line
//   wr_line_i       : write line from the processor
//   rd_beat_i       : store rd_data_i into read-line beat cnt, advance cnt
//   rd_data_i       : incoming read beat
//   wr_adv_i        : current write beat accepted, advance cnt
//   rd_line_o       : assembled read line
//   wr_beat_o       : write-line beat selected by cnt
//   cnt_o           : current beat index
module line_pack
    import host_bridge_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cnt_clr_i,
    input  logic              wr_load_i,
    input  logic [LINE_W-1:0] wr_line_i,
    input  logic              rd_beat_i,
    input  logic [HOST_W-1:0] rd_data_i,
    input  logic              wr_adv_i,
    output logic [LINE_W-1:0] rd_line_o,
    output logic [HOST_W-1:0] wr_beat_o,
    output logic [CNT_W-1:0]  cnt_o
);

    logic [LINE_W-1:0] rd_line_q;
    logic [LINE_W-1:0] wr_line_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (cnt_clr_i) begin
            cnt_q <= '0;
        end else if (rd_beat_i || wr_adv_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Read and write lines are kept apart so a write never disturbs the
    // last read line presented to the processor.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_line_q <= '0;
        end else if (rd_beat_i) begin
            rd_line_q[cnt_q*HOST_W +: HOST_W] <= rd_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_line_q <= '0;
        end else if (wr_load_i) begin
            wr_line_q <= wr_line_i;
        end
    end

    assign rd_line_o = rd_line_q;
    assign wr_beat_o = wr_line_q[cnt_q*HOST_W +: HOST_W];
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/host_line_bridge.sv
// host_line_bridge: turns mem_arb 512-bit line reads/writes into 8-beat
// 64-bit bursts on the host port, one transfer at a time.
//   clk, rst              : clock, synchronous active-high reset
//   op                    : 00 idle, 01 read, 11 write, 10 ignored
//   io_addr               : line byte address (low 6 bits ignored)
//   common_data_bus_out   : write line from the processor
//   common_data_bus_in    : last assembled read line
//   tx_done               : pulse, read line ready / write line accepted
//   rd_valid              : pulse, cycle after a read's tx_done
//   proto_err             : sticky, read beat seen outside RD_BEATS
//   host                  : host memory port (master side)
module host_line_bridge
    import host_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        op,
    input  logic [31:0]       io_addr,
    input  logic [LINE_W-1:0] common_data_bus_out,
    output logic [LINE_W-1:0] common_data_bus_in,
    output logic              tx_done,
    output logic              rd_valid,
    output logic              proto_err,
    host_line_bridge_if.master host
);

    bridge_state_t    state_q;
    logic [31:0]      addr_q;
    logic             hreq_valid_q;
    logic             hreq_wr_q;
    logic             hwr_valid_q;
    logic             hwr_last_q;
    logic             tx_done_q;
    logic             rd_valid_q;
    logic             proto_err_q;

    logic             rd_beat;
    logic             wr_adv;
    logic             wr_load;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt;
    logic             last_beat;

    assign rd_beat   = host.hrd_valid && (state_q == RD_BEATS);
    assign wr_adv    = hwr_valid_q && host.hwr_ready;
    assign wr_load   = (state_q == IDLE) && (op == OP_WR);
    assign cnt_clr   = (state_q == IDLE);
    assign last_beat = (cnt == CNT_W'(BEATS - 1));

    line_pack u_line_pack (
        .clk_i     (clk),
        .rst_i     (rst),
        .cnt_clr_i (cnt_clr),
        .wr_load_i (wr_load),
        .wr_line_i (common_data_bus_out),
        .rd_beat_i (rd_beat),
        .rd_data_i (host.hrd_data),
        .wr_adv_i  (wr_adv),
        .rd_line_o (common_data_bus_in),
        .wr_beat_o (host.hwr_data),
        .cnt_o     (cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            hreq_valid_q <= 1'b0;
            hreq_wr_q    <= 1'b0;
            hwr_valid_q  <= 1'b0;
            hwr_last_q   <= 1'b0;
            tx_done_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            tx_done_q  <= 1'b0;
            rd_valid_q <= 1'b0;

            if (host.hrd_valid && (state_q != RD_BEATS)) begin
                proto_err_q <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (op == OP_RD) begin
                        addr_q       <= line_align(io_addr);
                        hreq_valid_q <= 1'b1;
                        hreq_wr_q    <= 1'b0;
                        state_q      <= RD_REQ;
                    end else if (op == OP_WR) begin
                        addr_q       <= line_align(io_addr);
                        hreq_valid_q <= 1'b1;
                        hreq_wr_q    <= 1'b1;
                        state_q      <= WR_REQ;
                    end
                end
                RD_REQ: begin
                    if (host.hreq_ready) begin
                        hreq_valid_q <= 1'b0;
                        state_q      <= RD_BEATS;
                    end
                end
                RD_BEATS: begin
                    if (host.hrd_valid && last_beat) begin
                        tx_done_q <= 1'b1;
                        state_q   <= RD_DONE;
                    end
                end
                RD_DONE: begin
                    rd_valid_q <= 1'b1;
                    state_q    <= RD_VALID;
                end
                RD_VALID: begin
                    state_q <= IDLE;
                end
                WR_REQ: begin
                    if (host.hreq_ready) begin
                        hreq_valid_q <= 1'b0;
                        hwr_valid_q  <= 1'b1;
                        hwr_last_q   <= 1'b0;
                        state_q      <= WR_BEATS;
                    end
                end
                WR_BEATS: begin
                    if (host.hwr_ready) begin
                        if (last_beat) begin
                            hwr_valid_q <= 1'b0;
                            hwr_last_q  <= 1'b0;
                            tx_done_q   <= 1'b1;
                            state_q     <= WR_DONE;
                        end else begin
                            // Registered last flag: raise it as beat 6 is
                            // accepted so it lines up with beat 7.
                            hwr_last_q <= (cnt == CNT_W'(BEATS - 2));
                        end
                    end
                end
                WR_DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign host.hreq_valid = hreq_valid_q;
    assign host.hreq_wr    = hreq_wr_q;
    assign host.hreq_addr  = addr_q;
    assign host.hwr_valid  = hwr_valid_q;
    assign host.hwr_last   = hwr_last_q;
    assign tx_done         = tx_done_q;
    assign rd_valid        = rd_valid_q;
    assign proto_err       = proto_err_q;

endmodule

// File: doc/host_line_bridge.md
# host_line_bridge

Converts the processor memory arbiter's 512-bit cache-line transfers (op / io_addr / common_data_bus) into 8-beat, 64-bit bursts on the host memory port, and back. It sits directly below the processor's mem_arb. It returns read lines with the tx_done → rd_valid pulse pair that mem_arb expects, and acknowledges write lines with tx_done. One transfer is in flight at a time.

## Interface
- LINE_W, 512, cache-line width; fixed by the processor data bus.
- HOST_W, 64, host beat width; BEATS = LINE_W/HOST_W = 8.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  2  request from mem_arb: 00 idle, 01 line read, 11 line write, 10 reserved (ignored).
- io_addr  in  32  byte address of the line; bits [5:0] are ignored (forced to 0).
- common_data_bus_out  in  512  write line from the processor; valid with op=11.
- common_data_bus_in  out  512  assembled read line.
- tx_done  out  1  one-cycle pulse: read line present / write line accepted by host.
- rd_valid  out  1  one-cycle pulse, the cycle after a read's tx_done.
- hreq_valid / hreq_ready  out / in  1 / 1  host request handshake.
- hreq_wr  out  1  1 = write burst, 0 = read burst.
- hreq_addr  out  32  line-aligned byte address.
- hwr_valid / hwr_ready  out / in  1 / 1  write beat handshake.
- hwr_data  out  64  write beat. hwr_last  out  1  marks beat 7.
- hrd_valid  in  1  read beat strobe; no backpressure.
- hrd_data  in  64  read beat.
- proto_err  out  1  sticky flag: hrd_valid was seen outside RD_BEATS.

## Operation
- States: IDLE, RD_REQ, RD_BEATS, RD_DONE, RD_VALID, WR_REQ, WR_BEATS, WR_DONE.
- IDLE, op=01:
  - Latch {io_addr[31:6], 6'b0}.
  - Go to RD_REQ.
- IDLE, op=11:
  - Latch the address and common_data_bus_out into the line register.
  - Go to WR_REQ.
- IDLE, op=00 or 10: stay in IDLE.
- RD_REQ: hreq_valid=1, hreq_wr=0. On hreq_ready, go to RD_BEATS with beat counter = 0.
- RD_BEATS:
  - Each hrd_valid writes hrd_data into line bits [64k+63:64k], k = counter, then increments k.
  - After beat 7, go to RD_DONE.
- RD_DONE: tx_done=1, with common_data_bus_in showing the new line. Then go to RD_VALID.
- RD_VALID: rd_valid=1, then go to IDLE.
- WR_REQ: hreq_valid=1, hreq_wr=1. On hreq_ready, go to WR_BEATS.
- WR_BEATS:
  - hwr_valid=1 and hwr_data = line beat k.
  - hwr_last is asserted for k=7.
  - k advances on hwr_ready. When beat 7 is accepted, go to WR_DONE.
- WR_DONE: tx_done=1, then go to IDLE.
- op is sampled only in IDLE. Changes to op or io_addr during a transfer are ignored.
- mem_arb must drop op by the cycle after the final pulse (rd_valid for reads, tx_done for writes). If op is still non-zero in IDLE, a new transfer starts.
- common_data_bus_in updates only during RD_BEATS. It holds the last read line at all other times, including across writes.
  - Write data uses a separate register from the read line, so a write does not change common_data_bus_in.
- hrd_valid in any state other than RD_BEATS: the beat is discarded and proto_err is set. proto_err is cleared only by rst.
- Counter arithmetic: 3-bit counter, done at 7. No wrap-around into a second line.

## Timing
- Reset values: every output is 0 (buses included), state = IDLE, counter = 0, proto_err = 0.
- rst asserted mid-transfer aborts it on the next edge. No tx_done is issued. The host must also be reset.
- Best-case read, op sampled at cycle 0:
  - hreq_valid at cycle 1.
  - Beats at cycles 2–9.
  - tx_done at cycle 10, rd_valid at cycle 11, IDLE at cycle 12.
- Best-case write: hreq_valid at cycle 1, beats at cycles 2–9, tx_done at cycle 10.
- Stalls: every cycle hreq_ready or hwr_ready is low adds one cycle. Gaps in hrd_valid add one cycle per gap.
- hreq_valid and hwr_valid, once asserted, hold with stable payload until accepted.

## Structure
- Package host_bridge_pkg holds:
  - the op encodings OP_IDLE, OP_RD, OP_RSVD, OP_WR;
  - the state enum bridge_state_t;
  - LINE_W, HOST_W, BEATS.
- mem_arb also imports the op constants from this package.
- Sub-module line_pack: the 512↔64 beat pack/unpack registers with the counter. The FSM stays in host_line_bridge.

## Test plan
- Reset, then idle → all outputs 0 and proto_err = 0.
- Read of 0x2000_0040; host returns beats 0x0..0x7 with no stalls:
  - hreq_addr = 0x2000_0040;
  - tx_done at cycle 10 with common_data_bus_in[63:0] = 0 and [511:448] = 7;
  - rd_valid at cycle 11.
- Read of 0x1000_003F → hreq_addr = 0x1000_0000.
- Read with 3-cycle hreq_ready stall and one-cycle gaps between beats → same line, tx_done at cycle 10+3+7 = 20.
- Write of a line with word i = i, and hwr_ready toggling 1/0:
  - 8 beats are sent in order, hwr_last only on beat 7;
  - one tx_done, no rd_valid;
  - common_data_bus_in is unchanged.
- hrd_valid pulsed in IDLE → proto_err = 1 and stays set through a following good read. rst mid-RD_BEATS → IDLE, no tx_done.
